// File: rtl/caf_sweep_ctrl.sv
// caf_sweep_ctrl: sequences one CAF search. It programs the frequency-offset
// bins into the CAF core, streams LENGTH sample beats into it, and then
// captures the peak result. Bin k receives the offset (k - CENTER) * freq_inc,
// which is split into a magnitude and a sign.
module caf_sweep_ctrl #(
    parameter int PHASE_BITS    = 10,
    parameter int FOAS          = 3,
    parameter int FOAS_CNT_BITS = 3,
    parameter int LENGTH        = 5,
    parameter int LEN_CNT_BITS  = 3,
    parameter int OUT_MAX_BITS  = 64,
    parameter int TIMEOUT       = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [PHASE_BITS-1:0]    freq_inc,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [OUT_MAX_BITS-1:0]  res_max,
    output logic [FOAS_CNT_BITS-1:0] res_foas_index,
    output logic [LEN_CNT_BITS-1:0]  res_time_index,
    output logic                     cfg_req,
    output logic                     cfg_valid,
    output logic [PHASE_BITS-1:0]    cfg_step,
    output logic                     cfg_neg_shift,
    input  logic [FOAS_CNT_BITS-1:0] cfg_index,
    input  logic                     src_valid,
    output logic                     src_ready,
    output logic                     caf_tvalid,
    input  logic                     caf_tready,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [OUT_MAX_BITS-1:0]  res_max_in,
    input  logic [FOAS_CNT_BITS-1:0] res_foas_in,
    input  logic [LEN_CNT_BITS-1:0]  res_time_in
);

    localparam int TO_BITS = $clog2(TIMEOUT + 1);
    localparam logic [FOAS_CNT_BITS-1:0] CENTER    = FOAS_CNT_BITS'(FOAS / 2);
    localparam logic [FOAS_CNT_BITS-1:0] LAST_BIN  = FOAS_CNT_BITS'(FOAS - 1);
    localparam logic [LEN_CNT_BITS-1:0]  LAST_BEAT = LEN_CNT_BITS'(LENGTH - 1);
    localparam logic [TO_BITS-1:0]       LAST_TICK = TO_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StConfig,
        StStream,
        StWaitRes,
        StDone
    } state_t;

    state_t                   r_state;
    logic [PHASE_BITS-1:0]    r_freq_inc;
    logic                     r_err;
    logic [LEN_CNT_BITS-1:0]  r_beat;
    logic [TO_BITS-1:0]       r_tick;
    logic [OUT_MAX_BITS-1:0]  r_res_max;
    logic [FOAS_CNT_BITS-1:0] r_res_foas;
    logic [LEN_CNT_BITS-1:0]  r_res_time;

    logic                     w_beat;
    logic [FOAS_CNT_BITS-1:0] w_dist;
    logic [PHASE_BITS-1:0]    w_prod;

    assign w_beat = (r_state == StStream) && src_valid && caf_tready;

    // Bin offset magnitude; the product wraps modulo 2^PHASE_BITS, as the NCO does
    always_comb begin
        w_dist = (cfg_index >= CENTER) ? (cfg_index - CENTER) : (CENTER - cfg_index);
        w_prod = PHASE_BITS'(w_dist) * r_freq_inc;
    end

    // Search sequencer: state, counters, the freq_inc latch and the result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_freq_inc <= '0;
            r_err      <= 1'b0;
            r_beat     <= '0;
            r_tick     <= '0;
            r_res_max  <= '0;
            r_res_foas <= '0;
            r_res_time <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_freq_inc <= freq_inc;
                        r_err      <= 1'b0;
                        r_state    <= StReq;
                    end
                end
                StReq: begin
                    r_tick  <= '0;
                    r_state <= StConfig;
                end
                StConfig: begin
                    // Reaching the last bin takes priority over a timeout in the same cycle
                    if (cfg_index == LAST_BIN) begin
                        r_beat  <= '0;
                        r_state <= StStream;
                    end else if (r_tick == LAST_TICK) begin
                        r_err   <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                StStream: begin
                    if (w_beat) begin
                        if (r_beat == LAST_BEAT) begin
                            r_tick  <= '0;
                            r_state <= StWaitRes;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                StWaitRes: begin
                    // A result arriving on the final cycle still counts as success
                    if (res_valid) begin
                        r_res_max  <= res_max_in;
                        r_res_foas <= res_foas_in;
                        r_res_time <= res_time_in;
                        r_state    <= StDone;
                    end else if (r_tick == LAST_TICK) begin
                        r_err   <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Outputs are decoded from the state register; the stream handshake passes straight through
    always_comb begin
        busy           = (r_state != StIdle);
        done           = (r_state == StDone);
        err            = r_err;
        res_max        = r_res_max;
        res_foas_index = r_res_foas;
        res_time_index = r_res_time;
        cfg_req        = (r_state == StReq) || (r_state == StConfig);
        cfg_valid      = (r_state == StConfig);
        cfg_step       = '0;
        cfg_neg_shift  = 1'b0;
        src_ready      = 1'b0;
        caf_tvalid     = 1'b0;
        res_ready      = (r_state == StWaitRes);
        if (r_state == StConfig) begin
            cfg_step      = w_prod;
            cfg_neg_shift = (cfg_index < CENTER);
        end
        if (r_state == StStream) begin
            src_ready  = caf_tready;
            caf_tvalid = src_valid;
        end
    end

endmodule

// File: tb/tb_caf_sweep_ctrl.sv
// Bench for caf_sweep_ctrl: the bench itself plays the CAF core and the sample
// source. Randomized searches are checked against an arithmetic model of the bin
// offsets, the beat count, the result capture and the timeouts.
module tb_caf_sweep_ctrl;

    localparam int PB  = 10;
    localparam int NB  = 5;
    localparam int FB  = 3;
    localparam int LEN = 5;
    localparam int LB  = 3;
    localparam int OB  = 64;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PB-1:0] freq_inc = '0;
    logic          busy, done, err, cfg_req, cfg_valid, cfg_neg_shift;
    logic          src_ready, caf_tvalid, res_ready;
    logic [OB-1:0] res_max;
    logic [FB-1:0] res_foas_index;
    logic [LB-1:0] res_time_index;
    logic [PB-1:0] cfg_step;
    logic [FB-1:0] cfg_index = '0;
    logic          src_valid = 1'b0, caf_tready = 1'b0, res_valid = 1'b0;
    logic [OB-1:0] res_max_in = '0;
    logic [FB-1:0] res_foas_in = '0;
    logic [LB-1:0] res_time_in = '0;

    int total = 0;
    int bad = 0;

    // Model of the registered result and error state
    logic [OB-1:0] m_max = '0;
    logic [FB-1:0] m_foas = '0;
    logic [LB-1:0] m_time = '0;
    logic          m_err = 1'b0;

    caf_sweep_ctrl #(
        .PHASE_BITS(PB), .FOAS(NB), .FOAS_CNT_BITS(FB), .LENGTH(LEN),
        .LEN_CNT_BITS(LB), .OUT_MAX_BITS(OB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .freq_inc(freq_inc),
        .busy(busy), .done(done), .err(err), .res_max(res_max),
        .res_foas_index(res_foas_index), .res_time_index(res_time_index),
        .cfg_req(cfg_req), .cfg_valid(cfg_valid), .cfg_step(cfg_step),
        .cfg_neg_shift(cfg_neg_shift), .cfg_index(cfg_index),
        .src_valid(src_valid), .src_ready(src_ready), .caf_tvalid(caf_tvalid),
        .caf_tready(caf_tready), .res_valid(res_valid), .res_ready(res_ready),
        .res_max_in(res_max_in), .res_foas_in(res_foas_in), .res_time_in(res_time_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Offset of bin k is (k - NB/2) * finc; the core gets |offset| mod 2^PB and its sign
    function automatic int model_step(input int k, input int finc);
        int d;
        d = k - NB / 2;
        if (d < 0) d = -d;
        return (d * finc) % (1 << PB);
    endfunction

    function automatic logic model_neg(input int k);
        return (k < NB / 2);
    endfunction

    task automatic chk_result(input string tag);
        chk({tag, "_max"}, res_max, m_max);
        chk({tag, "_foas"}, 64'(res_foas_index), 64'(m_foas));
        chk({tag, "_time"}, 64'(res_time_index), 64'(m_time));
        chk({tag, "_err"}, 64'(err), 64'(m_err));
    endtask

    // res_mode: 0 = result delivered, 1 = WAIT_RES timeout, 2 = CONFIG timeout.
    // stream_mode: 0 = random handshakes, 1 = src_valid held high with tready toggling.
    // abort: pull reset after two beats.
    task automatic run_search(input int finc, input int stream_mode, input int res_mode,
                              input logic [OB-1:0] rmax, input logic [FB-1:0] rfoas,
                              input logic [LB-1:0] rtime, input bit abort);
        int beats;
        int cyc;
        int hold;
        @(negedge clk);
        start = 1'b1; freq_inc = PB'(finc); src_valid = 1'($urandom);
        #1 chk("idle_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0; freq_inc = PB'($urandom);
        m_err = 1'b0;
        #1;
        chk("req_cfg_req", 64'(cfg_req), 64'd1);
        chk("req_cfg_valid", 64'(cfg_valid), 64'd0);
        chk("req_busy_err", 64'({busy, err}), 64'b10);

        if (res_mode == 2) begin
            for (int i = 0; i < TO; i++) begin
                @(negedge clk);
                cfg_index = '0;
                #1 chk("cfg_stall_valid", 64'(cfg_valid), 64'd1);
            end
            @(negedge clk);
            m_err = 1'b1;
            #1;
            chk("cfg_to_done", 64'(done), 64'd1);
            chk_result("cfg_to");
            @(negedge clk);
            #1 chk("cfg_to_idle", 64'({busy, done}), 64'd0);
            return;
        end

        for (int k = 0; k < NB; k++) begin
            hold = (k == NB - 1) ? 1 : int'($urandom_range(1, 2));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                cfg_index = FB'(k);
                src_valid = 1'($urandom); caf_tready = 1'($urandom); start = 1'($urandom);
                #1;
                chk("cfg_valid", 64'({cfg_req, cfg_valid}), 64'b11);
                chk("cfg_step", 64'(cfg_step), 64'(model_step(k, finc)));
                chk("cfg_neg", 64'(cfg_neg_shift), 64'(model_neg(k)));
                chk("cfg_no_stream", 64'({caf_tvalid, src_ready}), 64'd0);
            end
        end

        beats = 0;
        cyc = 0;
        while (beats < LEN && cyc < 200) begin
            if (abort && beats == 2) break;
            @(negedge clk);
            cfg_index = FB'($urandom_range(0, NB - 1));
            start = 1'($urandom);
            src_valid = (stream_mode == 1) ? 1'b1 : 1'($urandom);
            caf_tready = (stream_mode == 1) ? 1'(cyc % 2) : 1'($urandom);
            #1;
            chk("stream_tvalid", 64'(caf_tvalid), 64'(src_valid));
            chk("stream_ready", 64'(src_ready), 64'(caf_tready));
            chk("stream_cfg_off", 64'({cfg_req, cfg_valid}), 64'd0);
            if (src_valid && caf_tready) beats++;
            cyc++;
        end
        if (cyc >= 200) chk("stream_budget", 64'(beats), 64'(LEN));

        if (abort) begin
            @(negedge clk);
            rst = 1'b1; src_valid = 1'b1; caf_tready = 1'b1; start = 1'b0;
            m_max = '0; m_foas = '0; m_time = '0; m_err = 1'b0;
            @(negedge clk);
            #1;
            chk("abort_busy_done", 64'({busy, done}), 64'd0);
            chk("abort_stream", 64'({caf_tvalid, src_ready, res_ready}), 64'd0);
            chk("abort_cfg", 64'({cfg_req, cfg_valid, cfg_neg_shift, cfg_step}), 64'd0);
            chk_result("abort");
            rst = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                #1 chk("abort_no_done", 64'({busy, done}), 64'd0);
            end
            return;
        end

        // First WAIT_RES cycle: the extra beat offered here must not pass
        @(negedge clk);
        src_valid = 1'b1; caf_tready = 1'b1; start = 1'b1; res_valid = 1'b0;
        #1;
        chk("wait_no_beat", 64'({caf_tvalid, src_ready}), 64'd0);
        chk("wait_res_ready", 64'({busy, res_ready, done}), 64'b110);

        if (res_mode == 1) begin
            for (int i = 1; i < TO; i++) begin
                @(negedge clk);
                start = 1'($urandom);
                #1 chk("wait_to_hold", 64'({res_ready, done}), 64'b10);
            end
            @(negedge clk);
            m_err = 1'b1;
            #1;
            chk("wait_to_done", 64'(done), 64'd1);
            chk_result("wait_to");
        end else begin
            hold = int'($urandom_range(0, 5));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                start = 1'($urandom);
                #1 chk("wait_hold", 64'({res_ready, done}), 64'b10);
            end
            @(negedge clk);
            start = 1'b0;
            res_valid = 1'b1; res_max_in = rmax; res_foas_in = rfoas; res_time_in = rtime;
            m_max = rmax; m_foas = rfoas; m_time = rtime;
            #1 chk("res_hs_ready", 64'(res_ready), 64'd1);
            @(negedge clk);
            res_valid = 1'b0; res_max_in = {$urandom, $urandom};
            #1;
            chk("res_done", 64'({busy, done, res_ready}), 64'b110);
            chk_result("res");
        end
        @(negedge clk);
        start = 1'b0; src_valid = 1'b0;
        #1;
        chk("post_idle", 64'({busy, done}), 64'd0);
        chk_result("post");
    endtask

    initial begin
        rst = 1'b1;
        src_valid = 1'b1; caf_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_cfg", 64'({cfg_req, cfg_valid, cfg_neg_shift, cfg_step}), 64'd0);
        chk("rst_stream", 64'({caf_tvalid, src_ready, res_ready}), 64'd0);
        chk_result("rst");
        rst = 1'b0;

        // Directed: freq_inc=100, held src_valid with toggling tready, fixed result
        run_search(100, 1, 0, 64'h1234, 3'd2, 3'd3, 1'b0);
        // Wrap-around step (1200 mod 1024) and a WAIT_RES timeout
        run_search(600, 0, 1, '0, '0, '0, 1'b0);
        // Next search clears the sticky error
        run_search(600, 0, 0, {$urandom, $urandom}, 3'($urandom), 3'($urandom), 1'b0);
        for (int n = 0; n < 4; n++) begin
            run_search(int'($urandom_range(0, (1 << PB) - 1)), int'($urandom_range(0, 1)), 0,
                       {$urandom, $urandom}, 3'($urandom), 3'($urandom), 1'b0);
        end
        // CONFIG timeout: the core never reaches the last bin
        run_search(37, 0, 2, '0, '0, '0, 1'b0);
        // Reset mid-STREAM after two beats
        run_search(250, 0, 0, '0, '0, '0, 1'b1);
        run_search(1023, 1, 0, {$urandom, $urandom}, 3'($urandom), 3'($urandom), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on the whole run so that a stuck design still ends
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
